// File: rtl/mux_pkg.sv
// Shared definitions for the 8:1 mux select serializer: FSM encodings, select width
// and start/last select index helpers.
package mux_pkg;

    localparam int unsigned MUX8_SEL_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_PAR  = 2'd2
    } state_t;

    // First select index of a word scan
    function automatic int unsigned start_idx(input int unsigned width, input int unsigned lsb_first);
        return (lsb_first != 0) ? 0 : width - 1;
    endfunction

    // Final select index of a word scan; the counter never steps past it
    function automatic int unsigned last_idx(input int unsigned width, input int unsigned lsb_first);
        return (lsb_first != 0) ? width - 1 : 0;
    endfunction

endpackage

// File: rtl/mux_sel_counter.sv
// Up/down mux select counter with synchronous load to the start index, step enable
// and a flag marking the final index of the scan.
module mux_sel_counter
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned SEL_W     = MUX8_SEL_W,
    parameter int unsigned LSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    output logic [SEL_W-1:0] sel,
    output logic             last_c
);

    localparam logic [SEL_W-1:0] START = SEL_W'(start_idx(WIDTH, LSB_FIRST));
    localparam logic [SEL_W-1:0] LAST  = SEL_W'(last_idx(WIDTH, LSB_FIRST));

    // Load wins over step so the final index reloads instead of wrapping
    always_ff @(posedge clk) begin
        if (rst) begin
            sel <= START;
        end else if (load) begin
            sel <= START;
        end else if (en) begin
            sel <= (LSB_FIRST != 0) ? sel + SEL_W'(1) : sel - SEL_W'(1);
        end
    end

    assign last_c = (sel == LAST);

endmodule

// File: rtl/mux_sel_serializer.sv
// Holds a parallel word on an external 8:1 mux, steps its select and registers the mux
// output as a backpressured bitstream. Optional PARITY_EN appends an even-parity bit.
module mux_sel_serializer
    import mux_pkg::*;
#(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned SEL_W     = MUX8_SEL_W,
    parameter int unsigned LSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic [WIDTH-1:0] mux_i,
    output logic [SEL_W-1:0] mux_sel,
    input  logic             mux_y,
    output logic             ser_out,
    output logic             ser_valid,
    input  logic             ser_ready,
    output logic             ser_last,
    output logic             busy
);

    state_t state_q;
    state_t state_d;
    logic   slot_free;
    logic   load_word;
    logic   capture;
    logic   cap_bit;
    logic   cap_last;
    logic   cnt_en;
    logic   cnt_load;
    logic   sel_last_c;

    assign slot_free = !ser_valid || ser_ready;
    assign in_ready  = (state_q == ST_IDLE) && !rst;
    assign busy      = (state_q != ST_IDLE) || ser_valid;

    mux_sel_counter #(
        .WIDTH     (WIDTH),
        .SEL_W     (SEL_W),
        .LSB_FIRST (LSB_FIRST)
    ) u_sel_counter (
        .clk    (clk),
        .rst    (rst),
        .load   (cnt_load),
        .en     (cnt_en),
        .sel    (mux_sel),
        .last_c (sel_last_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, word load, bit capture and select control
    always_comb begin
        state_d   = state_q;
        load_word = 1'b0;
        capture   = 1'b0;
        cap_bit   = 1'b0;
        cap_last  = 1'b0;
        cnt_en    = 1'b0;
        cnt_load  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    load_word = 1'b1;
                    cnt_load  = 1'b1;
                    state_d   = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (slot_free) begin
                    capture = 1'b1;
                    cap_bit = mux_y;
                    if (sel_last_c) begin
`ifdef PARITY_EN
                        state_d  = ST_PAR;
`else
                        cap_last = 1'b1;
                        cnt_load = 1'b1;
                        state_d  = ST_IDLE;
`endif
                    end else begin
                        cnt_en = 1'b1;
                    end
                end
            end
            ST_PAR: begin
`ifdef PARITY_EN
                // Select holds at the final index until the parity bit leaves
                if (slot_free) begin
                    capture  = 1'b1;
                    cap_bit  = ^mux_i;
                    cap_last = 1'b1;
                    cnt_load = 1'b1;
                    state_d  = ST_IDLE;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Held word and serial output register; a new capture takes priority over draining
    always_ff @(posedge clk) begin
        if (rst) begin
            mux_i     <= '0;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            ser_last  <= 1'b0;
        end else begin
            if (load_word) begin
                mux_i <= in_data;
            end
            if (capture) begin
                ser_out   <= cap_bit;
                ser_valid <= 1'b1;
                ser_last  <= cap_last;
            end else if (ser_ready) begin
                ser_valid <= 1'b0;
                ser_last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_sel_serializer.sv
// Directed scoreboard bench for mux_sel_serializer: LSB-first and MSB-first instances
// driving a behavioural 8:1 mux; parity expectations follow PARITY_EN.
module tb_mux_sel_serializer;

`ifdef PARITY_EN
    localparam int WB = 9;
`else
    localparam int WB = 8;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, mux_y, ser_out, ser_valid, ser_ready, ser_last, busy;
    logic [7:0] in_data, mux_i;
    logic [2:0] mux_sel;
    logic       m_in_valid, m_in_ready, m_mux_y, m_ser_out, m_ser_valid, m_ser_ready;
    logic       m_ser_last, m_busy;
    logic [7:0] m_in_data, m_mux_i;
    logic [2:0] m_mux_sel;

    int         errors = 0;
    int         checks = 0;
    logic [1:0] q0[$];
    logic [1:0] q1[$];
    bit         hs_prev0, ld_prev0, ld_prev1;
    int         lasts0;

    always #5 clk = ~clk;

    assign mux_y   = mux_i[mux_sel];
    assign m_mux_y = m_mux_i[m_mux_sel];

    mux_sel_serializer #(.WIDTH(8), .SEL_W(3), .LSB_FIRST(1)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .mux_i(mux_i), .mux_sel(mux_sel), .mux_y(mux_y), .ser_out(ser_out),
        .ser_valid(ser_valid), .ser_ready(ser_ready), .ser_last(ser_last), .busy(busy)
    );

    mux_sel_serializer #(.WIDTH(8), .SEL_W(3), .LSB_FIRST(0)) u_dut_msb (
        .clk(clk), .rst(rst), .in_valid(m_in_valid), .in_ready(m_in_ready),
        .in_data(m_in_data), .mux_i(m_mux_i), .mux_sel(m_mux_sel), .mux_y(m_mux_y),
        .ser_out(m_ser_out), .ser_valid(m_ser_valid), .ser_ready(m_ser_ready),
        .ser_last(m_ser_last), .busy(m_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected {bit, last} sequence for one word
    task automatic push_word(input bit msb, input logic [7:0] w);
        logic b;
        logic l;
        for (int k = 0; k < 8; k++) begin
            b = msb ? w[7-k] : w[k];
`ifdef PARITY_EN
            l = 1'b0;
`else
            l = (k == 7);
`endif
            if (msb) q1.push_back({b, l});
            else     q0.push_back({b, l});
        end
`ifdef PARITY_EN
        if (msb) q1.push_back({^w, 1'b1});
        else     q0.push_back({^w, 1'b1});
`endif
    endtask

    // One clock: record handshakes seen before the edge, score transferred bits after it
    task automatic tick();
        bit         hs0, hs1, ld0, ld1;
        logic [1:0] got0, got1, e;
        hs0  = ser_valid && ser_ready;
        hs1  = m_ser_valid && m_ser_ready;
        ld0  = in_valid && in_ready;
        ld1  = m_in_valid && m_in_ready;
        got0 = {ser_out, ser_last};
        got1 = {m_ser_out, m_ser_last};
        @(posedge clk);
        #1;
        hs_prev0 = hs0;
        ld_prev0 = ld0;
        ld_prev1 = ld1;
        if (hs0) begin
            check("lsb_bit_expected", 32'(q0.size() != 0), 32'd1);
            if (q0.size() != 0) begin
                e = q0.pop_front();
                check("lsb_bit_last", 32'(got0), 32'(e));
                if (got0[0]) lasts0++;
            end
        end
        if (hs1) begin
            check("msb_bit_expected", 32'(q1.size() != 0), 32'd1);
            if (q1.size() != 0) begin
                e = q1.pop_front();
                check("msb_bit_last", 32'(got1), 32'(e));
            end
        end
    endtask

    task automatic send0(input logic [7:0] w);
        bit done;
        done = 1'b0;
        push_word(1'b0, w);
        in_valid = 1'b1;
        in_data  = w;
        for (int n = 0; n < 30 && !done; n++) begin
            tick();
            if (ld_prev0) done = 1'b1;
        end
        in_valid = 1'b0;
        check("load_handshake", 32'(done), 32'd1);
    endtask

    task automatic wait_q0(input int sz, input string tag);
        for (int n = 0; n < 60 && q0.size() > sz; n++) tick();
        check(tag, 32'(q0.size()), 32'(sz));
    endtask

    // Run until the word has left; in_ready must already be up while the last bit is held
    task automatic drain0(input string tag, output int t);
        t = 0;
        while ((q0.size() != 0 || busy) && t < 60) begin
            tick();
            t++;
            if (ser_valid && ser_last) check("in_ready_at_last", 32'(in_ready), 32'd1);
        end
        check(tag, 32'(q0.size() == 0 && !busy), 32'd1);
    endtask

    initial begin
        int  t;
        bit  done;
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_data     = 8'h00;
        ser_ready   = 1'b1;
        m_in_valid  = 1'b0;
        m_in_data   = 8'h00;
        m_ser_ready = 1'b1;
        lasts0      = 0;
        tick();
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_mux_i", 32'(mux_i), 32'h00);
        check("rst_mux_sel", 32'(mux_sel), 32'd0);
        check("rst_ser", 32'({ser_out, ser_valid, ser_last, busy}), 32'd0);
        check("rst_msb_sel", 32'(m_mux_sel), 32'd7);
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", 32'(in_ready), 32'd1);

        // A5 LSB first, full rate
        send0(8'hA5);
        check("a5_mux_i", 32'(mux_i), 32'hA5);
        drain0("a5_drain", t);
        check("a5_cycles", 32'(t), 32'(WB + 1));

        // 3C with a 3-cycle stall after two transfers
        send0(8'h3C);
        wait_q0(WB - 2, "3c_two_bits");
        ser_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_valid", 32'(ser_valid), 32'd1);
            check("stall_ser_out", 32'(ser_out), 32'd1);
            check("stall_mux_sel", 32'(mux_sel), 32'd3);
            check("stall_mux_i", 32'(mux_i), 32'h3C);
        end
        ser_ready = 1'b1;
        drain0("3c_drain", t);

        // FF then 00 back to back with in_valid held
        lasts0 = 0;
        push_word(1'b0, 8'hFF);
        push_word(1'b0, 8'h00);
        in_valid = 1'b1;
        in_data  = 8'hFF;
        done     = 1'b0;
        for (int n = 0; n < 30 && !done; n++) begin
            tick();
            if (ld_prev0) done = 1'b1;
        end
        check("ff_load", 32'(done), 32'd1);
        in_data = 8'h00;
        wait_q0(WB, "ff_done");
        check("00_load_same_edge", 32'(ld_prev0), 32'd1);
        in_valid = 1'b0;
        tick();
        check("bubble_no_xfer", 32'(hs_prev0), 32'd0);
        tick();
        check("00_first_xfer", 32'(hs_prev0), 32'd1);
        drain0("00_drain", t);
        check("last_count", 32'(lasts0), 32'd2);

        // Reset mid-word, then a clean word
        send0(8'hF0);
        wait_q0(WB - 4, "f0_four_bits");
        rst       = 1'b1;
        ser_ready = 1'b0;
        #1;
        check("rst_blocks_ready", 32'(in_ready), 32'd0);
        tick();
        q0.delete();
        check("midrst_outputs", 32'({ser_out, ser_valid, ser_last, busy}), 32'd0);
        check("midrst_mux", 32'({mux_i, mux_sel}), 32'd0);
        rst       = 1'b0;
        ser_ready = 1'b1;
        tick();
        check("no_partial_output", 32'(ser_valid), 32'd0);
        send0(8'h81);
        drain0("81_drain", t);
        check("81_cycles", 32'(t), 32'(WB + 1));

        // MSB-first instance, select counts down
        push_word(1'b1, 8'h80);
        m_in_valid = 1'b1;
        m_in_data  = 8'h80;
        done       = 1'b0;
        for (int n = 0; n < 30 && !done; n++) begin
            tick();
            if (ld_prev1) done = 1'b1;
        end
        m_in_valid = 1'b0;
        check("msb_load", 32'(done), 32'd1);
        check("msb_start_sel", 32'(m_mux_sel), 32'd7);
        tick();
        check("msb_first_bit", 32'({m_ser_valid, m_ser_out}), 32'b11);
        check("msb_sel_down", 32'(m_mux_sel), 32'd6);
        for (int n = 0; n < 40 && (q1.size() != 0 || m_busy); n++) tick();
        check("msb_drain", 32'(q1.size() == 0 && !m_busy), 32'd1);
        check("msb_sel_reload", 32'(m_mux_sel), 32'd7);

        // 07: parity bit 1 appended when parity is built in
        send0(8'h07);
        drain0("07_drain", t);
        check("07_sel_reload", 32'(mux_sel), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
